// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the serial adder/subtractor: FSM state encoding and
// operation mode constants.
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_bit_cell.sv
// One-bit full adder / full subtractor cell; c_in/c_out carry a borrow when
// mode selects subtraction.
module addsub_bit_cell
    import serial_add_sub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic c_in,
    input  logic mode,
    output logic d,
    output logic c_out
);

    // Sum bit and carry/borrow out for the selected operation
    always_comb begin
        d = x ^ y ^ c_in;
        if (mode == MODE_SUB) begin
            c_out = (~x & y) | (~(x ^ y) & c_in);
        end else begin
            c_out = (x & y) | (x & c_in) | (y & c_in);
        end
    end

endmodule

// File: rtl/serial_add_sub.sv
// Serial add/subtract unit: processes STEP bits per clock LSB first and
// presents result, carry/borrow and signed overflow in a one-cycle DONE state.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cb,
    output logic             ovf
);

    localparam int NSTEPS = WIDTH / STEP;
    localparam int CNT_W  = $clog2(NSTEPS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEPS - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             mode_q, mode_d, cy_q, cy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cb_q, cb_d, ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;

    logic [STEP:0]    carry_s;
    logic [STEP-1:0]  sum_s;
    logic [WIDTH-1:0] res_shift_s;

    assign carry_s[0] = cy_q;

    for (genvar i = 0; i < STEP; i++) begin : g_cell
        addsub_bit_cell u_cell (
            .x     (a_q[i]),
            .y     (b_q[i]),
            .c_in  (carry_s[i]),
            .mode  (mode_q),
            .d     (sum_s[i]),
            .c_out (carry_s[i+1])
        );
    end

    // New bits enter at the top so the LSB-first stream lands in place after NSTEPS shifts
    if (WIDTH > STEP) begin : g_shift
        assign res_shift_s = {sum_s, res_q[WIDTH-1:STEP]};
    end else begin : g_noshift
        assign res_shift_s = sum_s;
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        cy_d     = cy_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        result_d = result_q;
        cb_d     = cb_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    a_d      = a;
                    b_d      = b;
                    mode_d   = mode;
                    cy_d     = 1'b0;
                    cnt_d    = '0;
                    res_d    = '0;
                    result_d = '0;
                    cb_d     = 1'b0;
                    ovf_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_q >> STEP;
                b_d   = b_q >> STEP;
                cy_d  = carry_s[STEP];
                res_d = res_shift_s;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = DONE;
                    result_d = res_shift_s;
                    cb_d     = carry_s[STEP];
                    // carry_s[STEP-1] is the carry into the MSB cell on the final step
                    ovf_d    = carry_s[STEP] ^ carry_s[STEP-1];
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            cy_q     <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            result_q <= '0;
            cb_q     <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            cy_q     <= cy_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            result_q <= result_d;
            cb_q     <= cb_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cb     = cb_q;
    assign ovf    = ovf_q;

endmodule
